// File: rtl/xera4_pkg.sv
// Shared definitions for the XERA4 video blitter: register offsets, CTRL bit
// positions, FSM state encoding and the default RAM address width.
package xera4_pkg;

  localparam int unsigned ADDR_W_DEF = 15;

  // Register offsets relative to BASE_PORT
  localparam logic [2:0] REG_SRC_L = 3'd0;
  localparam logic [2:0] REG_SRC_H = 3'd1;
  localparam logic [2:0] REG_DST_L = 3'd2;
  localparam logic [2:0] REG_DST_H = 3'd3;
  localparam logic [2:0] REG_LEN_L = 3'd4;
  localparam logic [2:0] REG_LEN_H = 3'd5;
  localparam logic [2:0] REG_FILL  = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  // CTRL bit positions (write: START/MODE/ABORT, read: DONEFLAG/MODE/busy)
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_MODE     = 1;
  localparam int unsigned CTRL_ABORT    = 2;
  localparam int unsigned CTRL_DONEFLAG = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FINISH  = 3'd4
  } blit_state_e;

endpackage

// File: rtl/blit_regs.sv
// Blitter register file: I/O port decode, SRC/DST/LEN/FILL/MODE/DONEFLAG
// storage with counter stepping, and the combinational readback mux.
// Ports: port_* CPU I/O bus; busy/idle/step/set_done from the FSM;
// start_c/abort_c/wmode_c decoded CTRL write; src/dst/len/fill/mode to datapath.
module blit_regs
  import xera4_pkg::*;
#(
  parameter logic [15:0] BASE_PORT = 16'h00F0,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       port_add,
  input  logic [7:0]        port_wdata,
  input  logic              port_we,
  output logic [7:0]        port_rdata,
  output logic              port_sel,
  input  logic              busy,
  input  logic              idle,
  input  logic              step,
  input  logic              set_done,
  output logic              start_c,
  output logic              abort_c,
  output logic              wmode_c,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] len,
  output logic [7:0]        fill,
  output logic              mode
);

  logic [15:0] off_full;
  logic [2:0]  off;
  logic        wr_c;
  logic        ctrl_wr_c;
  logic        doneflag;

  // Offset subtraction makes the range check a single compare
  assign off_full  = port_add - BASE_PORT;
  assign port_sel  = (off_full < 16'd8);
  assign off       = off_full[2:0];
  assign wr_c      = port_we && port_sel;
  assign ctrl_wr_c = wr_c && (off == REG_CTRL);
  assign abort_c   = ctrl_wr_c && port_wdata[CTRL_ABORT];
  // ABORT outranks START when both arrive in one write
  assign start_c   = ctrl_wr_c && port_wdata[CTRL_START] && !port_wdata[CTRL_ABORT];
  assign wmode_c   = port_wdata[CTRL_MODE];

  // Register writes (idle only) and counter stepping on each granted write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      fill     <= '0;
      mode     <= 1'b0;
      doneflag <= 1'b0;
    end else begin
      if (wr_c && !busy) begin
        unique case (off)
          REG_SRC_L: src[7:0]        <= port_wdata;
          REG_SRC_H: src[ADDR_W-1:8] <= port_wdata[ADDR_W-9:0];
          REG_DST_L: dst[7:0]        <= port_wdata;
          REG_DST_H: dst[ADDR_W-1:8] <= port_wdata[ADDR_W-9:0];
          REG_LEN_L: len[7:0]        <= port_wdata;
          REG_LEN_H: len[ADDR_W-1:8] <= port_wdata[ADDR_W-9:0];
          REG_FILL:  fill            <= port_wdata;
          default: ;
        endcase
      end
      if (start_c && idle) begin
        mode     <= wmode_c;
        doneflag <= 1'b0;
      end
      if (step) begin
        dst <= dst + ADDR_W'(1);
        len <= len - ADDR_W'(1);
        if (!mode) src <= src + ADDR_W'(1);
      end
      // Zero-length start clears and sets on the same edge: set must win
      if (set_done) doneflag <= 1'b1;
    end
  end

  // Readback mux; counters read live
  always_comb begin
    port_rdata = 8'h00;
    if (port_sel) begin
      unique case (off)
        REG_SRC_L: port_rdata = src[7:0];
        REG_SRC_H: port_rdata = 8'(src >> 8);
        REG_DST_L: port_rdata = dst[7:0];
        REG_DST_H: port_rdata = 8'(dst >> 8);
        REG_LEN_L: port_rdata = len[7:0];
        REG_LEN_H: port_rdata = 8'(len >> 8);
        REG_FILL:  port_rdata = fill;
        default:   port_rdata = {doneflag, 5'b0, mode, busy};
      endcase
    end
  end

endmodule

// File: rtl/video_blitter.sv
// XERA4 video blitter: copies System RAM to Video RAM or fills a Video RAM
// region with a constant byte, via req/gnt handshakes to the arbiter.
// Ports: port_* CPU I/O registers; busy/done status; sram_* read master;
// vram_* write master (vram_we mirrors vram_req).
module video_blitter
  import xera4_pkg::*;
#(
  parameter logic [15:0] BASE_PORT = 16'h00F0,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       port_add,
  input  logic [7:0]        port_wdata,
  input  logic              port_we,
  output logic [7:0]        port_rdata,
  output logic              port_sel,
  output logic              busy,
  output logic              done,
  output logic              sram_req,
  input  logic              sram_gnt,
  output logic [ADDR_W-1:0] sram_add,
  input  logic [7:0]        sram_rdata,
  output logic              vram_req,
  input  logic              vram_gnt,
  output logic [ADDR_W-1:0] vram_add,
  output logic [7:0]        vram_wdata,
  output logic              vram_we
);

  blit_state_e       state, state_nx;
  logic              busy_nx, done_nx, sram_req_nx, vram_req_nx;
  logic [ADDR_W-1:0] sram_add_nx, vram_add_nx;
  logic [7:0]        vram_wdata_nx;
  logic              step_c, set_done_c;
  logic              start_c, abort_c, wmode_c;
  logic [ADDR_W-1:0] src, dst, len;
  logic [7:0]        fill;
  logic              mode;

  assign vram_we = vram_req;
  assign step_c  = vram_req && vram_gnt;

  blit_regs #(.BASE_PORT(BASE_PORT), .ADDR_W(ADDR_W)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_add  (port_add),
    .port_wdata(port_wdata),
    .port_we   (port_we),
    .port_rdata(port_rdata),
    .port_sel  (port_sel),
    .busy      (busy),
    .idle      (state == IDLE),
    .step      (step_c),
    .set_done  (set_done_c),
    .start_c   (start_c),
    .abort_c   (abort_c),
    .wmode_c   (wmode_c),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill      (fill),
    .mode      (mode)
  );

  // State and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sram_req   <= 1'b0;
      sram_add   <= '0;
      vram_req   <= 1'b0;
      vram_add   <= '0;
      vram_wdata <= '0;
    end else begin
      state      <= state_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      sram_req   <= sram_req_nx;
      sram_add   <= sram_add_nx;
      vram_req   <= vram_req_nx;
      vram_add   <= vram_add_nx;
      vram_wdata <= vram_wdata_nx;
    end
  end

  // Next state and next output values; vram_wdata doubles as the data register
  always_comb begin
    state_nx      = state;
    busy_nx       = busy;
    done_nx       = 1'b0;
    sram_req_nx   = sram_req;
    sram_add_nx   = sram_add;
    vram_req_nx   = vram_req;
    vram_add_nx   = vram_add;
    vram_wdata_nx = vram_wdata;
    set_done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_c) begin
          if (len == '0) begin
            state_nx   = FINISH;
            done_nx    = 1'b1;
            set_done_c = 1'b1;
          end else if (wmode_c) begin
            state_nx      = WR_REQ;
            busy_nx       = 1'b1;
            vram_req_nx   = 1'b1;
            vram_add_nx   = dst;
            vram_wdata_nx = fill;
          end else begin
            state_nx    = RD_REQ;
            busy_nx     = 1'b1;
            sram_req_nx = 1'b1;
            sram_add_nx = src;
          end
        end
      end
      RD_REQ: begin
        if (sram_gnt) begin
          state_nx    = RD_WAIT;
          sram_req_nx = 1'b0;
        end
      end
      RD_WAIT: begin
        state_nx      = WR_REQ;
        vram_req_nx   = 1'b1;
        vram_add_nx   = dst;
        vram_wdata_nx = sram_rdata;
      end
      WR_REQ: begin
        if (vram_gnt) begin
          if (len == ADDR_W'(1)) begin
            state_nx    = FINISH;
            busy_nx     = 1'b0;
            done_nx     = 1'b1;
            set_done_c  = 1'b1;
            vram_req_nx = 1'b0;
          end else if (mode) begin
            vram_add_nx = dst + ADDR_W'(1);
          end else begin
            state_nx    = RD_REQ;
            vram_req_nx = 1'b0;
            sram_req_nx = 1'b1;
            sram_add_nx = src + ADDR_W'(1);
          end
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything; a write granted this edge still steps counters
    if (abort_c) begin
      state_nx    = IDLE;
      busy_nx     = 1'b0;
      done_nx     = 1'b0;
      sram_req_nx = 1'b0;
      vram_req_nx = 1'b0;
      set_done_c  = 1'b0;
    end
  end

endmodule

// File: tb/tb_video_blitter.sv
// Randomised self-checking bench for video_blitter: memory-backed arbiter
// model with optional random grant backpressure and a transfer-level model.
module tb_video_blitter;

  logic        clk;
  logic        rst_n;
  logic [15:0] port_add;
  logic [7:0]  port_wdata;
  logic        port_we;
  logic [7:0]  port_rdata;
  logic        port_sel;
  logic        busy, done;
  logic        sram_req, sram_gnt;
  logic [14:0] sram_add;
  logic [7:0]  sram_rdata;
  logic        vram_req, vram_gnt, vram_we;
  logic [14:0] vram_add;
  logic [7:0]  vram_wdata;

  video_blitter dut (
    .clk(clk), .rst_n(rst_n), .port_add(port_add), .port_wdata(port_wdata),
    .port_we(port_we), .port_rdata(port_rdata), .port_sel(port_sel),
    .busy(busy), .done(done), .sram_req(sram_req), .sram_gnt(sram_gnt),
    .sram_add(sram_add), .sram_rdata(sram_rdata), .vram_req(vram_req),
    .vram_gnt(vram_gnt), .vram_add(vram_add), .vram_wdata(vram_wdata),
    .vram_we(vram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sram_mem [0:32767];
  logic [14:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          busy_cyc, done_cnt, req_cnt;
  bit          bp;
  bit          rd_flag;
  logic [14:0] rd_addr;
  bit          p_spend, p_vpend;
  logic [14:0] p_sadd, p_vadd;
  logic [7:0]  p_vdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: arbiter/memory behaviour decided at the negedge, outputs checked after the edge
  task automatic tick();
    if (rd_flag) sram_rdata = sram_mem[rd_addr];
    else         sram_rdata = 8'($urandom);
    rd_flag  = 1'b0;
    sram_gnt = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    vram_gnt = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (sram_req && sram_gnt) begin
      rd_flag = 1'b1;
      rd_addr = sram_add;
    end
    if (vram_we && vram_req && vram_gnt) begin
      wa_q.push_back(vram_add);
      wd_q.push_back(vram_wdata);
    end
    p_spend = sram_req && !sram_gnt;
    p_sadd  = sram_add;
    p_vpend = vram_req && !vram_gnt;
    p_vadd  = vram_add;
    p_vdata = vram_wdata;
    @(posedge clk);
    @(negedge clk);
    busy_cyc += int'(busy);
    done_cnt += int'(done);
    req_cnt  += int'(sram_req || vram_req);
    if (p_spend && rst_n) begin
      check("sram_req_hold", sram_req, 1);
      check("sram_add_hold", sram_add, p_sadd);
    end
    if (p_vpend && rst_n) begin
      check("vram_req_hold", vram_req, 1);
      check("vram_add_hold", vram_add, p_vadd);
      check("vram_wdata_hold", vram_wdata, p_vdata);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] v);
    port_add   = 16'h00F0 + 16'(off);
    port_wdata = v;
    port_we    = 1'b1;
    tick();
    port_we    = 1'b0;
  endtask

  // Idle-only register read; consumes one clock
  task automatic rd(input logic [2:0] off, output logic [7:0] v);
    port_add = 16'h00F0 + 16'(off);
    #1;
    v = port_rdata;
    @(negedge clk);
  endtask

  task automatic check_regs(input logic [14:0] es, input logic [14:0] ed,
                            input logic [14:0] el, input logic [7:0] ec);
    logic [7:0] lo, hi;
    rd(3'd0, lo); rd(3'd1, hi); check("SRC", {hi, lo}, 32'(es));
    rd(3'd2, lo); rd(3'd3, hi); check("DST", {hi, lo}, 32'(ed));
    rd(3'd4, lo); rd(3'd5, hi); check("LEN", {hi, lo}, 32'(el));
    rd(3'd7, lo);               check("CTRL", lo, ec);
  endtask

  task automatic prog(input logic [14:0] s, input logic [14:0] d,
                      input logic [14:0] n, input logic [7:0] f);
    wr(3'd0, s[7:0]); wr(3'd1, 8'(s >> 8));
    wr(3'd2, d[7:0]); wr(3'd3, 8'(d >> 8));
    wr(3'd4, n[7:0]); wr(3'd5, 8'(n >> 8));
    wr(3'd6, f);
  endtask

  // Full transfer against the model: byte i goes to dst+i, from src+i (copy) or FILL
  task automatic run_xfer(input bit m, input logic [14:0] s, input logic [14:0] d,
                          input logic [14:0] n, input logic [7:0] f, input bit b);
    int          limit, cyc, e0;
    logic [14:0] ea;
    logic [7:0]  ed;
    bp = 1'b0;
    prog(s, d, n, f);
    wa_q.delete(); wd_q.delete();
    busy_cyc = 0; done_cnt = 0;
    bp = b;
    wr(3'd7, {6'd0, m, 1'b1});
    limit = (b ? 12 : 4) * int'(n) + 20;
    cyc = 0;
    while (done_cnt == 0 && cyc < limit) begin
      // A register write while busy must be ignored
      if (cyc == 5 && busy) wr(3'd2, 8'($urandom));
      else                  tick();
      cyc++;
    end
    repeat (3) tick();
    bp = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("busy_after", busy, 0);
    if (!b) check("busy_cycles", busy_cyc, m ? 32'(n) : 32'(3 * int'(n)));
    check("wr_count", wa_q.size(), 32'(n));
    e0 = n_err;
    for (int i = 0; i < int'(n) && i < wa_q.size(); i++) begin
      ea = d + 15'(i);
      ed = m ? f : sram_mem[s + 15'(i)];
      check("wr_addr", wa_q[i], ea);
      check("wr_data", wd_q[i], ed);
      if (n_err != e0) break;
    end
    check_regs(m ? s : s + n, d + n, 15'd0, {1'b1, 5'd0, m, 1'b0});
  endtask

  initial begin
    logic [7:0] v;
    int         cyc;
    rst_n = 1'b0; port_add = 16'h0; port_wdata = 8'h0; port_we = 1'b0;
    sram_gnt = 1'b0; vram_gnt = 1'b0; sram_rdata = 8'h0; bp = 1'b0; rd_flag = 1'b0;
    busy_cyc = 0; done_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 32768; i++) sram_mem[i] = 8'($urandom);
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sram_req", sram_req, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_vram_add", vram_add, 0);
    check_regs(15'd0, 15'd0, 15'd0, 8'h00);
    port_add = 16'h00F8; #1;
    check("sel_above", port_sel, 0);
    check("rdata_unsel", port_rdata, 0);
    port_add = 16'h00EF; #1;
    check("sel_below", port_sel, 0);
    port_add = 16'h00F6; #1;
    check("sel_in", port_sel, 1);
    @(negedge clk);

    // Directed copy of four known bytes
    sram_mem[15'h0100] = 8'h11; sram_mem[15'h0101] = 8'h22;
    sram_mem[15'h0102] = 8'h33; sram_mem[15'h0103] = 8'h44;
    run_xfer(1'b0, 15'h0100, 15'h1000, 15'd4, 8'h00, 1'b0);

    // Large fill and DST wrap
    run_xfer(1'b1, 15'h0000, 15'h0000, 15'd32000, 8'h5A, 1'b0);
    run_xfer(1'b1, 15'h1234, 15'h7FFE, 15'd3, 8'hFF, 1'b0);
    // Copy with SRC/DST wrap under backpressure
    run_xfer(1'b0, 15'h7FFE, 15'h7FFD, 15'd5, 8'h00, 1'b1);

    // Randomised transfers
    for (int k = 0; k < 16; k++)
      run_xfer(1'($urandom_range(0, 1)), 15'($urandom), 15'($urandom),
               15'($urandom_range(1, 40)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Abort after two of ten fill writes; the write granted with the abort completes
    prog(15'h0055, 15'h0200, 15'd10, 8'h3C);
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    wr(3'd7, 8'h03);
    cyc = 0;
    while (wa_q.size() < 2 && cyc < 50) begin tick(); cyc++; end
    check("abort_reach", wa_q.size(), 2);
    wr(3'd7, 8'h04);
    repeat (3) tick();
    check("abort_writes", wa_q.size(), 3);
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_vram_req", vram_req, 0);
    check("abort_last_addr", wa_q[wa_q.size() - 1], 15'h0202);
    check_regs(15'h0055, 15'h0203, 15'd7, 8'h02);

    // Zero length, fill then copy mode
    prog(15'h0001, 15'h0002, 15'd0, 8'h00);
    done_cnt = 0; req_cnt = 0; busy_cyc = 0;
    wr(3'd7, 8'h03);
    check("zl_done_next", done, 1);
    check("zl_busy", busy, 0);
    repeat (2) tick();
    check("zl_done_cnt", done_cnt, 1);
    check_regs(15'h0001, 15'h0002, 15'd0, 8'h82);
    wr(3'd7, 8'h01);
    repeat (2) tick();
    check("zl_done_cnt2", done_cnt, 2);
    check("zl_reqs", req_cnt, 0);
    check("zl_busy_cyc", busy_cyc, 0);
    check_regs(15'h0001, 15'h0002, 15'd0, 8'h80);

    // START together with ABORT while idle starts nothing
    wr(3'd4, 8'd5);
    req_cnt = 0; busy_cyc = 0;
    wr(3'd7, 8'h05);
    repeat (3) tick();
    check("sa_reqs", req_cnt, 0);
    check("sa_busy", busy_cyc, 0);
    rd(3'd4, v);
    check("sa_len", v, 8'd5);

    // Reset asserted for one cycle while in RD_WAIT
    prog(15'h0100, 15'h1000, 15'd4, 8'h77);
    wr(3'd7, 8'h01);
    tick();
    check("rw_sram_req", sram_req, 0);
    check("rw_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rr_busy", busy, 0);
    check("rr_done", done, 0);
    check("rr_sram_req", sram_req, 0);
    check("rr_sram_add", sram_add, 0);
    check("rr_vram_req", vram_req, 0);
    check("rr_vram_we", vram_we, 0);
    check("rr_vram_add", vram_add, 0);
    check("rr_vram_wdata", vram_wdata, 0);
    check_regs(15'd0, 15'd0, 15'd0, 8'h00);
    rd(3'd6, v);
    check("rr_fill", v, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
